// File: rtl/nibbler_sequencer.sv
// -----------------------------------------------------------------------------
// nibbler_sequencer
//
// Multi-cycle control unit for the Nibbler 4-bit CPU. It fetches instruction
// bytes from program ROM, decodes the opcode and walks the datapath through
// FETCH -> [OPERAND] -> EXEC (-> HALT). It also owns the carry and zero flags
// that the conditional jumps test.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       asynchronous, active-high
//   rom_data    program ROM byte at the current PC ([7:4] opcode)
//   alu_carry   ALU carry-out (for SUB: 1 = no borrow)
//   alu_zero    ALU result == 0
//   run         1 = execute, 0 = stall in FETCH (sampled in FETCH only)
//   resume      single-cycle pulse that leaves HALT
//   ir_load     latch the instruction byte
//   opr_load    latch the second (address low) byte
//   pc_inc      PC <= PC + 1
//   pc_load     PC <= {imm, operand}
//   notLoadA    active-low accumulator load
//   alu_op      00 pass B, 01 add, 10 sub, 11 nand
//   alu_src     ALU B operand: 0 = IR immediate, 1 = data memory
//   mem_we      write A to data memory at {imm, operand}
//   notLoadOut  active-low output-port load
//   flag_c      registered carry flag
//   flag_z      registered zero flag
//   halted      sequencer is in HALT
//
// Handshake: none. run is a level qualifier looked at only in FETCH; resume
// is looked at only while already in HALT, so a pulse that lands on the
// cycle that enters HALT is ignored.
// -----------------------------------------------------------------------------
module nibbler_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rom_data,
   input  logic       alu_carry,
   input  logic       alu_zero,
   input  logic       run,
   input  logic       resume,
   output logic       ir_load,
   output logic       opr_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       notLoadA,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic       mem_we,
   output logic       notLoadOut,
   output logic       flag_c,
   output logic       flag_z,
   output logic       halted
);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_OPERAND = 2'd1,
      ST_EXEC    = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LDI   = 4'h1;
   localparam logic [3:0] OP_ADDI  = 4'h2;
   localparam logic [3:0] OP_SUBI  = 4'h3;
   localparam logic [3:0] OP_NANDI = 4'h4;
   localparam logic [3:0] OP_CMPI  = 4'h5;
   localparam logic [3:0] OP_LD    = 4'h6;
   localparam logic [3:0] OP_ST    = 4'h7;
   localparam logic [3:0] OP_ADD   = 4'h8;
   localparam logic [3:0] OP_JMP   = 4'h9;
   localparam logic [3:0] OP_JC    = 4'hA;
   localparam logic [3:0] OP_JNC   = 4'hB;
   localparam logic [3:0] OP_JZ    = 4'hC;
   localparam logic [3:0] OP_JNZ   = 4'hD;
   localparam logic [3:0] OP_OUT   = 4'hE;
   localparam logic [3:0] OP_HLT   = 4'hF;

   state_t     state_q, state_d;
   // Only the opcode nibble is kept here; the immediate / address-high nibble
   // is held by the datapath's own copy of the instruction byte.
   logic [3:0] ir_q, ir_d;
   logic       flag_c_q, flag_c_d;
   logic       flag_z_q, flag_z_d;

   logic [3:0] fetch_op;
   logic       fetch_two_byte;
   logic       exec_writes_a;
   logic       exec_sets_c;

   // Two-byte opcodes are LD, ST, ADD and the jump group 9..D.
   assign fetch_op       = rom_data[7:4];
   assign fetch_two_byte = (fetch_op >= OP_LD) && (fetch_op <= OP_JNZ);

   assign exec_writes_a = (ir_q == OP_LDI) || (ir_q == OP_ADDI) ||
                          (ir_q == OP_SUBI) || (ir_q == OP_NANDI) ||
                          (ir_q == OP_LD) || (ir_q == OP_ADD);
   assign exec_sets_c   = (ir_q == OP_ADDI) || (ir_q == OP_SUBI) ||
                          (ir_q == OP_CMPI) || (ir_q == OP_ADD);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_FETCH;
         ir_q     <= 4'h0;
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         flag_c_q <= flag_c_d;
         flag_z_q <= flag_z_d;
      end
   end

   // Next-state, IR and flag update
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      flag_c_d = flag_c_q;
      flag_z_d = flag_z_q;
      case (state_q)
         ST_FETCH: begin
            if (run) begin
               ir_d    = fetch_op;
               state_d = fetch_two_byte ? ST_OPERAND : ST_EXEC;
            end
         end
         ST_OPERAND: begin
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (exec_writes_a || (ir_q == OP_CMPI)) flag_z_d = alu_zero;
            if (exec_sets_c) flag_c_d = alu_carry;
            state_d = (ir_q == OP_HLT) ? ST_HALT : ST_FETCH;
         end
         ST_HALT: begin
            if (resume) state_d = ST_FETCH;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Outputs: from state, IR and flags (plus run in FETCH)
   always_comb begin
      ir_load    = 1'b0;
      opr_load   = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      notLoadA   = 1'b1;
      alu_op     = 2'b00;
      alu_src    = 1'b0;
      mem_we     = 1'b0;
      notLoadOut = 1'b1;
      case (state_q)
         ST_FETCH: begin
            ir_load = run;
            pc_inc  = run;
         end
         ST_OPERAND: begin
            opr_load = 1'b1;
            pc_inc   = 1'b1;
         end
         ST_EXEC: begin
            notLoadA = ~exec_writes_a;
            alu_src  = (ir_q == OP_LD) || (ir_q == OP_ADD);
            case (ir_q)
               OP_ADDI, OP_ADD:  alu_op = 2'b01;
               OP_SUBI, OP_CMPI: alu_op = 2'b10;
               OP_NANDI:         alu_op = 2'b11;
               default:          alu_op = 2'b00;
            endcase
            case (ir_q)
               OP_ST:   mem_we     = 1'b1;
               OP_OUT:  notLoadOut = 1'b0;
               OP_JMP:  pc_load    = 1'b1;
               OP_JC:   pc_load    = flag_c_q;
               OP_JNC:  pc_load    = ~flag_c_q;
               OP_JZ:   pc_load    = flag_z_q;
               OP_JNZ:  pc_load    = ~flag_z_q;
               OP_NOP, OP_HLT: begin
               end
               default: begin
               end
            endcase
         end
         default: begin
         end
      endcase
   end

   assign flag_c = flag_c_q;
   assign flag_z = flag_z_q;
   assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Bench for nibbler_sequencer. A driver issues whole instructions cycle by
// cycle and pushes the expected output word for every cycle into exp_q; a
// monitor pops and compares on each falling edge. The reference model works
// at instruction level: opcode properties and flag rules, plus a cycle list.
module tb_nibbler_sequencer;
   localparam int W = 13;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rom_data;
   logic       alu_carry, alu_zero, run, resume;
   logic       ir_load, opr_load, pc_inc, pc_load, notLoadA;
   logic [1:0] alu_op;
   logic       alu_src, mem_we, notLoadOut, flag_c, flag_z, halted;

   nibbler_sequencer dut (
      .clk(clk), .reset(reset), .rom_data(rom_data),
      .alu_carry(alu_carry), .alu_zero(alu_zero), .run(run), .resume(resume),
      .ir_load(ir_load), .opr_load(opr_load), .pc_inc(pc_inc),
      .pc_load(pc_load), .notLoadA(notLoadA), .alu_op(alu_op),
      .alu_src(alu_src), .mem_we(mem_we), .notLoadOut(notLoadOut),
      .flag_c(flag_c), .flag_z(flag_z), .halted(halted)
   );

   always #5 clk = ~clk;

   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic mc = 1'b0;
   logic mz = 1'b0;

   wire [W-1:0] act = {ir_load, opr_load, pc_inc, pc_load, notLoadA, alu_op,
                       alu_src, mem_we, notLoadOut, flag_c, flag_z, halted};

   task automatic check(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h (irl,oprl,pci,pcl,nLA,op2,src,we,nLO,c,z,h)",
                  name, a, e);
      end
   endtask

   function automatic logic [W-1:0] pack(bit irl, bit oprl, bit pci, bit pcl,
                                         bit nla, logic [1:0] aop, bit src,
                                         bit we, bit nlo, bit h);
      return {irl, oprl, pci, pcl, nla, aop, src, we, nlo, mc, mz, h};
   endfunction

   function automatic logic [W-1:0] idle(bit h);
      return pack(0, 0, 0, 0, 1, 2'b00, 0, 0, 1, h);
   endfunction

   function automatic bit two_byte(logic [3:0] op);
      return (op == 4'h6) || (op == 4'h7) || (op == 4'h8) ||
             ((op >= 4'h9) && (op <= 4'hD));
   endfunction

   function automatic bit writes_a(logic [3:0] op);
      return (op == 4'h1) || (op == 4'h2) || (op == 4'h3) ||
             (op == 4'h4) || (op == 4'h6) || (op == 4'h8);
   endfunction

   // Expected EXEC-cycle outputs, using the flags as they stand before EXEC.
   function automatic logic [W-1:0] exec_vec(logic [3:0] op);
      logic [1:0] aop;
      bit pcl;
      case (op)
         4'h2, 4'h8: aop = 2'b01;
         4'h3, 4'h5: aop = 2'b10;
         4'h4:       aop = 2'b11;
         default:    aop = 2'b00;
      endcase
      pcl = (op == 4'h9) || ((op == 4'hA) && mc) || ((op == 4'hB) && !mc) ||
            ((op == 4'hC) && mz) || ((op == 4'hD) && !mz);
      return pack(0, 0, 0, pcl, !writes_a(op), aop, (op == 4'h6) || (op == 4'h8),
                  op == 4'h7, op != 4'hE, 0);
   endfunction

   // One clock cycle: drive inputs just after the rising edge, queue expectation.
   task automatic step(input logic [7:0] rd, input bit r, input bit rs,
                       input bit c, input bit z, input logic [W-1:0] e);
      @(posedge clk);
      #1;
      rom_data  = rd;
      run       = r;
      resume    = rs;
      alu_carry = c;
      alu_zero  = z;
      exp_q.push_back(e);
   endtask

   task automatic do_stall(input int n);
      for (int i = 0; i < n; i++)
         step(8'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom), idle(0));
   endtask

   task automatic do_instr(input logic [7:0] b1, input logic [7:0] b2,
                           input bit c, input bit z, input bit exec_resume);
      logic [3:0] op;
      op = b1[7:4];
      step(b1, 1, 1'($urandom), 1'($urandom), 1'($urandom),
           pack(1, 0, 1, 0, 1, 2'b00, 0, 0, 1, 0));
      if (two_byte(op))
         step(b2, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              pack(0, 1, 1, 0, 1, 2'b00, 0, 0, 1, 0));
      // run and rom_data are irrelevant in EXEC
      step(8'($urandom), 1'($urandom), exec_resume, c, z, exec_vec(op));
      if (writes_a(op) || op == 4'h5) mz = z;
      if (op == 4'h2 || op == 4'h3 || op == 4'h5 || op == 4'h8) mc = c;
   endtask

   // Caller has just run HLT; spend n cycles in HALT, resume on the last one.
   task automatic do_halt(input int n);
      for (int i = 0; i < n - 1; i++)
         step(8'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom), idle(1));
      step(8'($urandom), 1'($urandom), 1, 1'($urandom), 1'($urandom), idle(1));
   endtask

   // Monitor
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cycle%0d", cyc), act, e);
         end
      end
   end

   initial begin
      logic [7:0] b1;
      reset = 1'b1; rom_data = 8'h00; alu_carry = 0; alu_zero = 0;
      run = 0; resume = 0;
      step(8'h00, 0, 0, 0, 0, idle(0));
      @(negedge clk); #2;
      reset = 1'b0;

      // LDI 5, ADDI C: flags both set after the second EXEC
      do_instr(8'h15, 8'h00, 1, 1, 0);
      do_instr(8'h2C, 8'h00, 1, 1, 0);

      // Reset during OPERAND of JMP 0x9A,0x34
      step(8'h9A, 1, 0, 0, 0, pack(1, 0, 1, 0, 1, 2'b00, 0, 0, 1, 0));
      step(8'h34, 1, 0, 0, 0, pack(0, 1, 1, 0, 1, 2'b00, 0, 0, 1, 0));
      @(negedge clk); #1;
      reset = 1'b1; run = 1'b0;
      mc = 1'b0; mz = 1'b0;
      #1;
      check("async_reset", act, idle(0));
      step(8'($urandom), 0, 0, 1, 1, idle(0));
      @(negedge clk); #2;
      reset = 1'b0;
      do_instr(8'h10, 8'h00, 0, 1, 0);     // FETCH right after reset

      // CMPI (zero) then JZ taken; CMPI (non-zero) then JZ not taken
      do_instr(8'h53, 8'h00, 1, 1, 0);
      do_instr(8'hC1, 8'h23, 0, 0, 0);
      do_instr(8'h53, 8'h00, 0, 0, 0);
      do_instr(8'hC1, 8'h23, 1, 1, 0);

      // ST then LD
      do_instr(8'h7F, 8'hFF, 1, 1, 0);
      do_instr(8'h6F, 8'hFF, 0, 0, 0);

      // HLT: resume on the entry edge is ignored, the one 3 cycles later is not
      do_instr(8'hF0, 8'h00, 0, 0, 1);
      do_halt(3);

      // Stall 5 cycles then OUT
      do_stall(5);
      do_instr(8'hE0, 8'h00, 0, 0, 0);

      // Randomized program
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) do_stall($urandom_range(1, 3));
         b1 = 8'($urandom);
         do_instr(b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         if (b1[7:4] == 4'hF) do_halt($urandom_range(1, 4));
      end

      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d left want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
